// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: native valid/ready memory port (request fields, completion and read data)
interface mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
  modport master(output valid, instr, addr, wdata, wstrb, input ready, rdata);
  modport slave(input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master memory port arbiter with watchdog; MEM_ARBITER_ROUND_ROBIN_EN selects round-robin ties
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master mem,
  output logic          timeout
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);
  state_t     state;
  logic [7:0] cnt;
  logic       last;
  logic       g0, g1, cur_valid, expire, done, win1, tie1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  assign tie1 = !last;
`else
  assign tie1 = 1'b0;
`endif
  always_comb begin
    g0        = state == GRANT0;
    g1        = state == GRANT1;
    cur_valid = g0 ? m0.valid : g1 ? m1.valid : 1'b0;
    expire    = cur_valid && cnt == LIMIT && !mem.ready;
    done      = cur_valid && (mem.ready || expire);
    win1      = m1.valid && (!m0.valid || tie1);
    mem.valid = g0 || g1;
    mem.instr = g0 ? m0.instr : g1 ? m1.instr : 1'b0;
    mem.addr  = g0 ? m0.addr  : g1 ? m1.addr  : 32'h0;
    mem.wdata = g0 ? m0.wdata : g1 ? m1.wdata : 32'h0;
    mem.wstrb = g0 ? m0.wstrb : g1 ? m1.wstrb : 4'h0;
    m0.ready  = g0 && done;
    m1.ready  = g1 && done;
    m0.rdata  = g0 && cur_valid && mem.ready ? mem.rdata : 32'h0;
    m1.rdata  = g1 && cur_valid && mem.ready ? mem.rdata : 32'h0;
    timeout   = expire;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'h0;
      last  <= 1'b1;
    end else if (state == IDLE) begin
      cnt <= 8'h0;
      if (m0.valid || m1.valid) begin
        state <= win1 ? GRANT1 : GRANT0;
        last  <= win1;
      end
    end else if (!cur_valid || done) begin
      state <= IDLE;
    end else begin
      cnt <= cnt + 8'h1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT=4)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic timeout;
  int   checks = 0;
  int   failures = 0;
  mem_arbiter_if m0_bus();
  mem_arbiter_if m1_bus();
  mem_arbiter_if mem_bus();
  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus), .mem(mem_bus), .timeout(timeout)
  );
  always #5 clk = ~clk;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    reset = 1'b1;
    {m0_bus.valid, m0_bus.instr, m0_bus.addr, m0_bus.wdata, m0_bus.wstrb} = '0;
    {m1_bus.valid, m1_bus.instr, m1_bus.addr, m1_bus.wdata, m1_bus.wstrb} = '0;
    mem_bus.ready = 1'b0;
    mem_bus.rdata = 32'h0;
    tick;
    tick;
    #1;
    chk("rst_mem_valid", mem_bus.valid, 0);
    chk("rst_mem_addr", mem_bus.addr, 0);
    chk("rst_m0_ready", m0_bus.ready, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    // single read from m0, memory answers two cycles after mem_valid
    tick;
    m0_bus.valid = 1'b1;
    m0_bus.addr = 32'h100;
    #1;
    chk("rd_n_mem_valid", mem_bus.valid, 0);
    tick;
    #1;
    chk("rd_n1_mem_valid", mem_bus.valid, 1);
    chk("rd_n1_mem_addr", mem_bus.addr, 32'h100);
    chk("rd_n1_m0_ready", m0_bus.ready, 0);
    tick;
    #1;
    chk("rd_n2_m0_ready", m0_bus.ready, 0);
    tick;
    mem_bus.ready = 1'b1;
    mem_bus.rdata = 32'hDEADBEEF;
    #1;
    chk("rd_m0_ready", m0_bus.ready, 1);
    chk("rd_m0_rdata", m0_bus.rdata, 32'hDEADBEEF);
    chk("rd_m1_ready", m1_bus.ready, 0);
    chk("rd_timeout", timeout, 0);
    tick;
    m0_bus.valid = 1'b0;
    mem_bus.ready = 1'b0;
    #1;
    chk("rd_idle_mem_valid", mem_bus.valid, 0);
    chk("rd_idle_m0_ready", m0_bus.ready, 0);
    // tie held with mem_ready always 1, starting from reset (last=1)
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m0_bus.valid = 1'b1;
    m0_bus.addr = 32'h40;
    m1_bus.valid = 1'b1;
    m1_bus.addr = 32'h80;
    mem_bus.ready = 1'b1;
    mem_bus.rdata = 32'h5A5A0001;
    #1;
    chk("tie_idle0", mem_bus.valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      #1;
      chk($sformatf("tie%0d_m0_ready", i), m0_bus.ready, (RR && i[0]) ? 0 : 1);
      chk($sformatf("tie%0d_m1_ready", i), m1_bus.ready, (RR && i[0]) ? 1 : 0);
      chk($sformatf("tie%0d_addr", i), mem_bus.addr, (RR && i[0]) ? 32'h80 : 32'h40);
      tick;
      #1;
      chk($sformatf("tie%0d_idle", i), mem_bus.valid, 0);
    end
    m0_bus.valid = 1'b0;
    m1_bus.valid = 1'b0;
    mem_bus.ready = 1'b0;
    // write from m1
    tick;
    m1_bus.valid = 1'b1;
    m1_bus.addr = 32'h20;
    m1_bus.wdata = 32'h12345678;
    m1_bus.wstrb = 4'b0011;
    tick;
    #1;
    chk("wr_mem_wstrb", mem_bus.wstrb, 4'b0011);
    chk("wr_mem_wdata", mem_bus.wdata, 32'h12345678);
    chk("wr_mem_addr", mem_bus.addr, 32'h20);
    chk("wr_m1_ready_early", m1_bus.ready, 0);
    mem_bus.ready = 1'b1;
    #1;
    chk("wr_m1_ready", m1_bus.ready, 1);
    chk("wr_m0_ready", m0_bus.ready, 0);
    chk("wr_m0_rdata", m0_bus.rdata, 0);
    tick;
    m1_bus.valid = 1'b0;
    m1_bus.wstrb = 4'b0000;
    mem_bus.ready = 1'b0;
    // watchdog expiry with mem_ready held low
    m0_bus.valid = 1'b1;
    m0_bus.addr = 32'h300;
    mem_bus.rdata = 32'hAAAA5555;
    for (int i = 1; i <= 4; i++) begin
      tick;
      #1;
      chk($sformatf("to_c%0d_m0_ready", i), m0_bus.ready, 0);
      chk($sformatf("to_c%0d_timeout", i), timeout, 0);
    end
    tick;
    #1;
    chk("to_m0_ready", m0_bus.ready, 1);
    chk("to_m0_rdata", m0_bus.rdata, 0);
    chk("to_timeout", timeout, 1);
    tick;
    m0_bus.valid = 1'b0;
    #1;
    chk("to_idle_mem_valid", mem_bus.valid, 0);
    chk("to_idle_timeout", timeout, 0);
    // mem_ready in the expiry cycle wins over the watchdog
    m0_bus.valid = 1'b1;
    for (int i = 1; i <= 4; i++) tick;
    tick;
    mem_bus.ready = 1'b1;
    mem_bus.rdata = 32'hCAFEF00D;
    #1;
    chk("col_timeout", timeout, 0);
    chk("col_m0_ready", m0_bus.ready, 1);
    chk("col_m0_rdata", m0_bus.rdata, 32'hCAFEF00D);
    tick;
    m0_bus.valid = 1'b0;
    mem_bus.ready = 1'b0;
    // master withdraws mid-grant: no ready, no timeout
    m1_bus.valid = 1'b1;
    tick;
    m1_bus.valid = 1'b0;
    #1;
    chk("drop_m1_ready", m1_bus.ready, 0);
    chk("drop_timeout", timeout, 0);
    tick;
    #1;
    chk("drop_mem_valid", mem_bus.valid, 0);
    // reset one cycle into GRANT1
    m1_bus.valid = 1'b1;
    m1_bus.addr = 32'h80;
    tick;
    #1;
    chk("rg_mem_valid", mem_bus.valid, 1);
    reset = 1'b1;
    tick;
    #1;
    chk("rg_rst_mem_valid", mem_bus.valid, 0);
    chk("rg_rst_mem_addr", mem_bus.addr, 0);
    chk("rg_rst_m1_ready", m1_bus.ready, 0);
    chk("rg_rst_timeout", timeout, 0);
    reset = 1'b0;
    m0_bus.valid = 1'b1;
    m0_bus.addr = 32'h40;
    mem_bus.ready = 1'b1;
    tick;
    #1;
    chk("rg_tie_m0_ready", m0_bus.ready, 1);
    chk("rg_tie_m1_ready", m1_bus.ready, 0);
    chk("rg_tie_addr", mem_bus.addr, 32'h40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
